// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: ALU opcodes, sequencer commands
// and the packed ALU micro-op request driven onto the ALU ports.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      kADD = 3'd0,
      kSUB = 3'd1,
      kAND = 3'd2,
      kOR  = 3'd3,
      kXOR = 3'd4,
      kSLL = 3'd5,
      kSRL = 3'd6,
      kEQ  = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      CMD_NORM = 2'd0,
      CMD_DIV  = 2'd1,
      CMD_CNT  = 2'd2,
      CMD_MUL  = 2'd3
   } cmd_e;

   typedef struct packed {
      alu_op_e    op;
      logic       ci;
      logic [7:0] a;
      logic [7:0] b;
   } alu_req_t;

   localparam alu_req_t ALU_IDLE = '{op: kADD, ci: 1'b0, a: 8'h00, b: 8'h00};

endpackage

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle command sequencer driving a combinational ALU with one
// micro-op per clock (normalize, divide, 4-bit pattern count, 8x8 multiply).
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   start, cmd, opa, opb, pat   command request and operands (sampled in IDLE)
//   busy, done, err       status; done is a one-cycle pulse, err valid with done
//   res_lo, res_hi        results, held until the next completion
//   alu_op/ci/a/b         registered ALU micro-op drive (idle outside RUN)
//   alu_out/co/zero       ALU response, captured at each RUN edge
//   abort                 only when ALU_SEQ_ABORT_EN is defined: stop a run early
//
// Optional feature macro: ALU_SEQ_ABORT_EN
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned DIV_LIMIT     = 255,
   parameter int unsigned NORM_ZERO_CNT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] opa,
   input  logic [7:0] opb,
   input  logic [3:0] pat,
`ifdef ALU_SEQ_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] res_lo,
   output logic [7:0] res_hi,
   output logic [2:0] alu_op,
   output logic       alu_ci,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_out,
   input  logic       alu_co,
   input  logic       alu_zero
);

   localparam logic [7:0] DIV_LIM  = 8'(DIV_LIMIT);
   localparam logic [7:0] ZERO_CNT = 8'(NORM_ZERO_CNT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

   state_e     state;
   cmd_e       cmd_q;
   logic [7:0] opa_q, opb_q;
   logic [3:0] pat_q;
   logic [7:0] x_q;       // NORM value / DIV remainder / MUL low half
   logic [7:0] hi_q;      // MUL high half
   logic [7:0] cnt_q;     // shift count / quotient / match count
   logic [2:0] idx_q;     // CNT window index / MUL step
   logic       noop_q;    // run has a single cycle with no ALU op
   alu_req_t   req_q;

   cmd_e       cmd_in;
   logic [7:0] init_x, init_cnt;
   logic       init_noop;
   alu_req_t   req_init, req_n;
   logic [7:0] x_n, hi_n, cnt_n;
   logic [2:0] idx_n;
   logic       last, err_n;
   logic [7:0] lo_r, hi_r;

   // Micro-op to issue for a given working state.
   function automatic alu_req_t req_for(input cmd_e c, input logic [7:0] x,
                                        input logic [7:0] hi, input logic [2:0] idx,
                                        input logic [7:0] a_op, input logic [7:0] b_op,
                                        input logic [3:0] p);
      alu_req_t   r;
      logic [2:0] sh;
      r  = ALU_IDLE;
      sh = 3'(3'd4 - idx);
      case (c)
         CMD_NORM: begin r.op = kSLL; r.a = x; end
         CMD_DIV:  begin r.op = kSUB; r.a = x; r.b = b_op; end
         CMD_CNT:  begin r.op = kEQ;  r.a = {4'h0, 4'(a_op >> sh)}; r.b = {4'h0, p}; end
         CMD_MUL:  begin r.op = kADD; r.a = hi; r.b = x[0] ? a_op : 8'h00; end
         default:  r = ALU_IDLE;
      endcase
      return r;
   endfunction

   // Command start setup and per-cycle iteration step.
   always_comb begin
      cmd_in    = cmd_e'(cmd);
      init_x    = opa;
      init_cnt  = 8'h00;
      init_noop = 1'b0;
      case (cmd_in)
         CMD_NORM: begin
            init_noop = opa[7] || (opa == 8'h00);
            if (opa == 8'h00) init_cnt = ZERO_CNT;
         end
         CMD_DIV: begin
            // Divide by zero: results fall out of the normal mapping (q=FF, rem=OPA)
            init_noop = (opb == 8'h00);
            if (opb == 8'h00) init_cnt = 8'hFF;
         end
         CMD_MUL: init_x = opb;
         default: init_x = opa;
      endcase
      req_init = init_noop ? ALU_IDLE
                           : req_for(cmd_in, init_x, 8'h00, 3'd0, opa, opb, pat);

      x_n   = x_q;
      hi_n  = hi_q;
      cnt_n = cnt_q;
      idx_n = 3'(idx_q + 3'd1);
      last  = 1'b0;
      err_n = 1'b0;
      if (noop_q) begin
         last  = 1'b1;
         err_n = (cmd_q == CMD_DIV);
      end else begin
         case (cmd_q)
            CMD_NORM: begin
               x_n   = alu_out;
               cnt_n = 8'(cnt_q + 8'd1);
               last  = alu_out[7] || (alu_out == 8'h00);
            end
            CMD_DIV: begin
               if (alu_co) begin
                  last = 1'b1;
               end else begin
                  x_n   = alu_out;
                  cnt_n = 8'(cnt_q + 8'd1);
                  if (cnt_n == DIV_LIM) begin
                     last  = 1'b1;
                     err_n = 1'b1;
                  end
               end
            end
            CMD_CNT: begin
               cnt_n = 8'(cnt_q + {7'h00, ~alu_zero});
               last  = (idx_q == 3'd4);
            end
            CMD_MUL: begin
               hi_n = {alu_co, alu_out[7:1]};
               x_n  = {alu_out[0], x_q[7:1]};
               last = (idx_q == 3'd7);
            end
            default: last = 1'b1;
         endcase
      end
`ifdef ALU_SEQ_ABORT_EN
      if (abort) begin
         last  = 1'b1;
         err_n = 1'b1;
      end
`endif
      case (cmd_q)
         CMD_NORM: begin lo_r = x_n;   hi_r = cnt_n; end
         CMD_DIV:  begin lo_r = cnt_n; hi_r = x_n;   end
         CMD_CNT:  begin lo_r = cnt_n; hi_r = 8'h00; end
         default:  begin lo_r = x_n;   hi_r = hi_n;  end
      endcase
      req_n = last ? ALU_IDLE
                   : req_for(cmd_q, x_n, hi_n, idx_n, opa_q, opb_q, pat_q);
   end

   // Sequencer FSM with registered status, results and ALU drive.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         cmd_q  <= CMD_NORM;
         opa_q  <= 8'h00;
         opb_q  <= 8'h00;
         pat_q  <= 4'h0;
         x_q    <= 8'h00;
         hi_q   <= 8'h00;
         cnt_q  <= 8'h00;
         idx_q  <= 3'd0;
         noop_q <= 1'b0;
         req_q  <= ALU_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         res_lo <= 8'h00;
         res_hi <= 8'h00;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cmd_q  <= cmd_in;
                  opa_q  <= opa;
                  opb_q  <= opb;
                  pat_q  <= pat;
                  x_q    <= init_x;
                  hi_q   <= 8'h00;
                  cnt_q  <= init_cnt;
                  idx_q  <= 3'd0;
                  noop_q <= init_noop;
                  req_q  <= req_init;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               x_q   <= x_n;
               hi_q  <= hi_n;
               cnt_q <= cnt_n;
               idx_q <= idx_n;
               req_q <= req_n;
               if (last) begin
                  state  <= S_FIN;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  err    <= err_n;
                  res_lo <= lo_r;
                  res_hi <= hi_r;
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign alu_op = req_q.op;
   assign alu_ci = req_q.ci;
   assign alu_a  = req_q.a;
   assign alu_b  = req_q.b;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, arithmetic reference model, directed
// boundary cases plus randomized commands.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [1:0] cmd;
   logic [7:0] opa, opb;
   logic [3:0] pat;
`ifdef ALU_SEQ_ABORT_EN
   logic       abort;
`endif
   logic       busy, done, err;
   logic [7:0] res_lo, res_hi;
   logic [2:0] alu_op;
   logic       alu_ci;
   logic [7:0] alu_a, alu_b;
   logic [7:0] alu_out;
   logic       alu_co, alu_zero;
   logic [8:0] alu_t;

   int checks   = 0;
   int failures = 0;

   alu_seq dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .cmd      (cmd),
      .opa      (opa),
      .opb      (opb),
      .pat      (pat),
`ifdef ALU_SEQ_ABORT_EN
      .abort    (abort),
`endif
      .busy     (busy),
      .done     (done),
      .err      (err),
      .res_lo   (res_lo),
      .res_hi   (res_hi),
      .alu_op   (alu_op),
      .alu_ci   (alu_ci),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_out  (alu_out),
      .alu_co   (alu_co),
      .alu_zero (alu_zero)
   );

   always #5 clk = ~clk;

   // Combinational ALU: kSUB carry-out is the borrow, kEQ returns 1 on equality.
   always_comb begin
      alu_t = 9'h000;
      case (alu_op)
         kADD:    alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
         kSUB:    alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_ci};
         kSLL:    alu_t = {alu_a, 1'b0};
         kEQ:     alu_t = {8'h00, alu_a == alu_b};
         default: alu_t = 9'h000;
      endcase
      alu_out  = alu_t[7:0];
      alu_co   = alu_t[8];
      alu_zero = (alu_t[7:0] == 8'h00);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Expected results from the command definitions using plain arithmetic.
   function automatic void ref_model(input int c, input int a, input int b, input int p,
                                     output int lo, output int hi, output int er,
                                     output int n, output int nops);
      int v, s, q;
      lo = 0; hi = 0; er = 0; n = 1; nops = -1;
      case (c)
         0: begin
            if (a == 0) begin
               lo = 0; hi = 8; n = 1; nops = 0;
            end else begin
               v = a; s = 0;
               while (v < 128) begin v = v * 2; s++; end
               lo = v; hi = s; n = (s == 0) ? 1 : s; nops = s;
            end
         end
         1: begin
            if (b == 0) begin
               er = 1; lo = 255; hi = a; n = 1; nops = 0;
            end else begin
               q = a / b;
               lo = q; hi = a % b;
               if (q >= 255) begin er = 1; n = 255; nops = 255; end
               else begin n = q + 1; nops = q + 1; end
            end
         end
         2: begin
            for (int i = 0; i < 5; i++)
               if (((a >> (4 - i)) % 16) == p) lo++;
            n = 5; nops = 5;
         end
         default: begin
            lo = (a * b) % 256; hi = (a * b) / 256; n = 8;
         end
      endcase
   endfunction

   task automatic run_cmd(input int c, input int a, input int b, input int p,
                          input int restart_at, input int abort_at);
      int lo, hi, er, n, nops, k, busy_bad, ops, dsum;
      logic [2:0] exp_op;
      string t;
      ref_model(c, a, b, p, lo, hi, er, n, nops);
      if (abort_at > 0) begin
         er = 1; n = abort_at; lo = abort_at; hi = a - abort_at * b; nops = abort_at;
      end
      case (c)
         0:       exp_op = kSLL;
         1:       exp_op = kSUB;
         2:       exp_op = kEQ;
         default: exp_op = kADD;
      endcase
      t = $sformatf("cmd%0d a=%0h b=%0h p=%0h", c, a, b, p);
      @(negedge clk);
      start = 1'b1; cmd = 2'(c); opa = 8'(a); opb = 8'(b); pat = 4'(p);
      @(negedge clk);
      start = 1'b0; opa = 8'($urandom); opb = 8'($urandom); pat = 4'($urandom);
      k = 1; busy_bad = 0; ops = 0;
      while (k <= 300 && !done) begin
         if (!busy) busy_bad++;
         if (alu_op == exp_op) ops++;
         start = (k == restart_at);
         if (start) cmd = 2'($urandom);
`ifdef ALU_SEQ_ABORT_EN
         abort = (k == abort_at);
`endif
         @(negedge clk);
         k++;
      end
      start = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      check({t, " latency"}, 32'(k), 32'(n + 1));
      check({t, " done"}, 32'(done), 32'd1);
      check({t, " res_lo"}, 32'(res_lo), 32'(lo));
      check({t, " res_hi"}, 32'(res_hi), 32'(hi));
      check({t, " err"}, 32'(err), 32'(er));
      check({t, " busy_fin"}, 32'(busy), 32'd0);
      check({t, " busy_run"}, 32'(busy_bad), 32'd0);
      check({t, " alu_idle"}, 32'({alu_op, alu_ci, alu_a, alu_b}), 32'({kADD, 17'h0}));
      if (nops >= 0) check({t, " alu_ops"}, 32'(ops), 32'(nops));
      // START presented in FIN must not launch a new command.
      start = 1'b1; cmd = 2'($urandom); opa = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      check({t, " fin_start"}, 32'(busy), 32'd0);
      dsum = 0;
      for (int i = 0; i < 3; i++) begin
         dsum += int'(done);
         @(negedge clk);
      end
      check({t, " extra_done"}, 32'(dsum), 32'd0);
   endtask

   int rc, ra, rb, rp, dsum;

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; cmd = 2'd0; opa = 8'h00; opb = 8'h00; pat = 4'h0;
`ifdef ALU_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst res", 32'({err, res_hi, res_lo}), 32'd0);
      check("rst alu", 32'({alu_op, alu_ci, alu_a, alu_b}), 32'({kADD, 17'h0}));
      @(negedge clk);
      reset_n = 1'b1;

      run_cmd(0, 8'h13, 0, 0, 0, 0);
      run_cmd(0, 8'h00, 0, 0, 0, 0);
      run_cmd(0, 8'h80, 0, 0, 0, 0);
      run_cmd(0, 8'h01, 0, 0, 0, 0);
      run_cmd(1, 100, 7, 0, 0, 0);
      run_cmd(1, 100, 0, 0, 0, 0);
      run_cmd(1, 255, 1, 0, 0, 0);
      run_cmd(1, 254, 1, 0, 0, 0);
      run_cmd(1, 3, 5, 0, 0, 0);
      run_cmd(2, 8'hAA, 0, 4'hA, 0, 0);
      run_cmd(2, 8'hAA, 0, 4'hF, 0, 0);
      run_cmd(3, 255, 255, 0, 0, 0);
      run_cmd(3, 255, 0, 0, 0, 0);
      // START while busy in DIV 200/1 is ignored.
      run_cmd(1, 200, 1, 0, 5, 0);
`ifdef ALU_SEQ_ABORT_EN
      run_cmd(1, 200, 1, 0, 0, 3);
`endif

      // Reset in the middle of a multiply, after a non-zero result is held.
      run_cmd(3, 255, 255, 0, 0, 0);
      @(negedge clk);
      start = 1'b1; cmd = 2'd3; opa = 8'hFF; opb = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst res", 32'({err, res_hi, res_lo}), 32'd0);
      check("midrst alu", 32'({alu_op, alu_ci, alu_a, alu_b}), 32'({kADD, 17'h0}));
      @(negedge clk);
      reset_n = 1'b1;
      dsum = 0;
      for (int i = 0; i < 12; i++) begin
         dsum += int'(done) + int'(busy);
         @(negedge clk);
      end
      check("midrst no_done", 32'(dsum), 32'd0);

      for (int i = 0; i < 40; i++) begin
         rc = int'($urandom_range(0, 3));
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         rp = int'($urandom_range(0, 15));
         if (rc == 0) ra = ra >> $urandom_range(0, 7);
         if (rc == 1) rb = int'($urandom_range(0, 40));
         if (rc == 2 && $urandom_range(0, 1) == 1) rp = (ra >> $urandom_range(0, 4)) % 16;
         run_cmd(rc, ra, rb, rp, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
